fifo_wr_arb: RTL and testbench

Round-robin write-port arbiter that shares the single write port of the test FIFO (`winc`/`wdata`, `wfull`/`afull`) among NREQ requesters in the write-clock domain. It grants one requester at a time for a bounded burst and throttles on full/almost-full. It also acknowledges every word it accepts. It sits between the bench's producer agents and the FIFO write side.

---
 rtl/fifo_wr_arb.sv | 69 ++++++
 tb/tb_fifo_wr_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing one FIFO write port among NREQ bursting requesters
module fifo_wr_arb #(
  parameter int DSIZE = 8,
  parameter int NREQ = 4,
  parameter int BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       grant,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  input  logic                  wfull,
  input  logic                  afull,
  output logic                  busy
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [0:0] IDLE = 1'b0, XFER = 1'b1;
  logic [0:0] state;
  logic [PW-1:0] ptr, owner, pick, idx;
  logic [CW-1:0] cnt;
  logic can_write, take, last;
  assign can_write = !wfull && !(afull && winc);
  assign busy = state == XFER;
  assign take = busy && req[owner] && can_write;
  assign ack = take ? NREQ'(1) << owner : '0;
  assign last = !req[owner] || (take && cnt + 1'b1 == CW'(BURST));
  always_comb begin
    pick = ptr;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (req[idx]) pick = idx;
    end
  end
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      grant <= '0;
      cnt <= '0;
      winc <= 1'b0;
      wdata <= '0;
    end else if (state == IDLE) begin
      winc <= 1'b0;
      if (|req) begin
        state <= XFER;
        owner <= pick;
        grant <= NREQ'(1) << pick;
        cnt <= '0;
      end
    end else begin
      winc <= take;
      if (take) begin
        wdata <= req_data[owner*DSIZE +: DSIZE];
        cnt <= cnt + 1'b1;
      end
      if (last) begin
        state <= IDLE;
        grant <= '0;
        ptr <= owner == PW'(NREQ - 1) ? '0 : owner + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: randomized producers with a queue-based round-robin model and a write/grant scoreboard
module tb_fifo_wr_arb;
  localparam int DSIZE = 8, NREQ = 4, BURST = 4;
  typedef struct {logic [NREQ-1:0] g; int len;} gexp_t;
  logic clk = 0, rst = 1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*DSIZE-1:0] req_data = '0;
  logic [NREQ-1:0] ack, grant;
  logic winc, busy;
  logic [DSIZE-1:0] wdata;
  logic wfull = 0, afull = 0;
  int errors = 0, checks = 0;
  logic [DSIZE-1:0] pq[NREQ][$];
  logic [DSIZE-1:0] exp_w[$];
  gexp_t exp_g[$];
  int model_ptr = 0, p_full = 0, p_af = 0;
  bit sb_on = 1;

  always #5 clk = ~clk;

  fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
    .wclk(clk), .wrst(rst), .req(req), .req_data(req_data), .ack(ack), .grant(grant),
    .winc(winc), .wdata(wdata), .wfull(wfull), .afull(afull), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = pq[i].size() != 0;
      req_data[i*DSIZE +: DSIZE] = pq[i].size() != 0 ? pq[i][0] : '0;
    end
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (pq[i].size() != 0) return 0;
    return 1;
  endfunction

  // Producers: a word is consumed only if its ack was seen and no reset hit that edge
  logic [NREQ-1:0] pa_ack;
  logic pa_rst;
  always begin
    @(negedge clk);
    pa_ack = ack;
    pa_rst = rst;
    @(posedge clk);
    #1;
    if (!pa_rst)
      for (int i = 0; i < NREQ; i++) if (pa_ack[i] && pq[i].size() != 0) void'(pq[i].pop_front());
    wfull = int'($urandom_range(99)) < p_full;
    afull = int'($urandom_range(99)) < p_af;
    drive();
  end

  // Monitor: writes, grant order, burst length and blocking rules
  logic [NREQ-1:0] pg = '0;
  int acnt = 0, elen = 0;
  gexp_t me;
  always @(negedge clk) begin
    if (rst || !sb_on) begin
      pg = '0;
      acnt = 0;
    end else begin
      check("ack_owner", ack & ~grant, 0);
      check("busy", busy, grant != 0);
      if (wfull || (afull && winc)) check("ack_blocked", ack, 0);
      if (winc) begin
        if (exp_w.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_write: got %0h, expected none at %0t", wdata, $time);
        end else check("wdata", wdata, exp_w.pop_front());
      end
      if (pg != 0 && grant != pg) check("burst_len", acnt, elen);
      if (grant != 0 && grant != pg) begin
        if (exp_g.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_grant: got %0h, expected none at %0t", grant, $time);
          elen = 0;
        end else begin
          me = exp_g.pop_front();
          check("grant", grant, me.g);
          elen = me.len;
        end
        acnt = 0;
      end
      if (ack != 0) acnt++;
      pg = grant;
    end
  end

  task automatic load_phase(input int c0, input int c1, input int c2, input int c3,
                            input bit seq, input int pf, input int pa);
    int c[NREQ];
    logic [DSIZE-1:0] m[NREQ][$];
    logic [DSIZE-1:0] d;
    int o;
    gexp_t e;
    c = '{c0, c1, c2, c3};
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < c[i]; k++) begin
        d = seq ? DSIZE'(8'h11 * (k + 1)) : DSIZE'($urandom);
        pq[i].push_back(d);
        m[i].push_back(d);
      end
    forever begin
      o = -1;
      for (int j = 0; j < NREQ; j++)
        if (o < 0 && m[(model_ptr + j) % NREQ].size() != 0) o = (model_ptr + j) % NREQ;
      if (o < 0) break;
      e.g = NREQ'(1) << o;
      e.len = 0;
      while (e.len < BURST && m[o].size() != 0) begin
        exp_w.push_back(m[o].pop_front());
        e.len++;
      end
      exp_g.push_back(e);
      model_ptr = (o + 1) % NREQ;
    end
    p_full = pf;
    p_af = pa;
    drive();
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (t < 3000 && !(all_empty() && !busy && !winc && exp_w.size() == 0));
    check("drain_done", t < 3000, 1);
    check("grants_left", exp_g.size(), 0);
  endtask

  task automatic wait_winc();
    int t = 0;
    while (!winc && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("winc_seen", winc, 1);
  endtask

  initial begin
    int n, t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_winc", winc, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    load_phase(3, 0, 0, 0, 1, 0, 0);
    wait_winc();
    repeat (2) begin
      @(negedge clk);
      check("single_run", winc, 1);
    end
    @(negedge clk);
    check("single_gap", winc, 0);
    wait_idle();
    load_phase(8, 8, 8, 8, 0, 0, 0);
    wait_idle();
    load_phase(0, 0, 6, 0, 0, 0, 0);
    wait_winc();
    p_full = 100;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("full_ack", ack, 0);
      check("full_grant", grant, 4'b0100);
      if (k > 1) check("full_winc", winc, 0);
    end
    p_full = 0;
    wait_idle();
    load_phase(5, 0, 2, 0, 0, 0, 0);
    wait_idle();
    load_phase(0, 6, 0, 0, 0, 0, 100);
    wait_idle();
    repeat (6) begin
      load_phase($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                 $urandom_range(0, 9), 0, $urandom_range(0, 40), $urandom_range(0, 50));
      wait_idle();
    end
    p_full = 0;
    p_af = 0;
    @(negedge clk);
    sb_on = 0;
    for (int k = 0; k < 6; k++) pq[3].push_back(DSIZE'($urandom));
    drive();
    n = 0;
    t = 0;
    while (n < 2 && t < 50) begin
      @(negedge clk);
      t++;
      if (ack[3]) n++;
    end
    check("pre_rst_acks", n, 2);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_winc", winc, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", ack, 0);
    t = 0;
    while (grant != 4'b1000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("regrant", grant, 4'b1000);
    n = 0;
    t = 0;
    while (grant == 4'b1000 && t < 50) begin
      if (ack != 0) n++;
      @(negedge clk);
      t++;
    end
    check("regrant_burst", n, 4);
    check("regrant_left", pq[3].size(), 0);
    repeat (3) @(negedge clk);
    model_ptr = 0;
    sb_on = 1;
    load_phase(3, 5, 2, 7, 0, 20, 30);
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
